prefetch_buffer: RTL and testbench
==================================

PREFETCH_BUFFER -- requirements
Module: prefetch_buffer

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH 32, instruction word width; ADDR_WIDTH 32, pc/address width; DEPTH 4, queue entries (power of 2, >=2); INSTR_BYTES 4, pc increment per fetch; RESET_PC 0, first fetch address; NOP_WORD 0, instruction presented when not valid.
REQ-002 Ports SHALL be:
- clock  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- redirect  in  1  pc change / flush request.
- redirect_pc  in  ADDR_WIDTH  new fetch address.
- hold  in  1  downstream stall.
- mem_req  out  1  fetch request (address enable).
- mem_addr  out  ADDR_WIDTH  fetch address.
- mem_ready  in  1  memory accepts request this cycle.
- mem_valid  in  1  response valid; responses return in request order.
- mem_data  in  DATA_WIDTH  response word.
- out_valid  out  1  out_instruction/out_pc valid for decode.
- out_instruction  out  DATA_WIDTH  instruction to decode.
- out_pc  out  ADDR_WIDTH  address of out_instruction.
- flushing  out  1  stale responses still outstanding.

Function
REQ-003 Block SHALL hold fetch_pc, a DEPTH-entry FIFO of {instruction, pc}, count (0..DEPTH), outstanding (0..DEPTH), stale (0..DEPTH); counters $clog2(DEPTH+1) bits.
REQ-004 mem_req SHALL be 1 iff !reset && !redirect && count+outstanding < DEPTH; mem_addr SHALL equal fetch_pc.
REQ-005 Request accepted iff mem_req && mem_ready: fetch_pc += INSTR_BYTES (modulo 2^ADDR_WIDTH wrap), outstanding += 1.
REQ-006 hold SHALL NOT stop prefetching; requests continue until credits (REQ-004) are exhausted.
REQ-007 Each mem_valid SHALL decrement outstanding; if stale>0 the response is discarded and stale decrements, else {mem_data, resp_pc} is pushed and resp_pc += INSTR_BYTES.
REQ-008 out_valid SHALL equal count>0; out_instruction/out_pc SHALL show the FIFO head, NOP_WORD/0 when count==0.
REQ-009 Pop SHALL occur iff out_valid && !hold && !redirect; push and pop in one cycle SHALL leave count unchanged.
REQ-010 Latency: mem_valid at cycle t SHALL appear on out_valid at t+1 (without bypass, REQ-017).
REQ-011 redirect SHALL, next edge: empty FIFO (count=0), fetch_pc=resp_pc=redirect_pc, stale = outstanding after this cycle's REQ-007 decrement; no request issued, no pop that cycle.
REQ-012 A mem_valid in the redirect cycle SHALL be discarded regardless of stale.
REQ-013 Back-to-back redirects: last one wins; stale accumulates all in-flight requests.
REQ-014 flushing SHALL equal stale>0.
REQ-015 FIFO SHALL never overflow; credit rule guarantees count+outstanding<=DEPTH at all times.

Reset
REQ-016 With reset high at an edge: fetch_pc=resp_pc=RESET_PC, count=outstanding=stale=0, out_valid=0, out_instruction=NOP_WORD, out_pc=0, flushing=0; mem_req=0 while reset high; reset mid-operation drops in-flight responses without tracking (memory reset with block).

Configuration
REQ-017 Macro PREFETCH_BYPASS_EN: when defined, if count==0 and a non-discarded mem_valid arrives, out_valid/out_instruction/out_pc SHALL present it in the same cycle; if !hold it is consumed and not pushed, else pushed. When undefined, REQ-010 latency applies and outputs are FIFO-only.

Verification
REQ-018 Reset then mem_ready=1, one-cycle response, hold=0 -> mem_addr 0,4,8,...; out_pc 0,4,8 on consecutive cycles, out_valid from cycle 2 (cycle 1 with bypass).
REQ-019 DEPTH=4, hold=1, memory always ready/responding -> exactly 4 requests issued, mem_req low, count=4; release hold -> one pop per cycle, pcs 0,4,8,12 in order.
REQ-020 3 requests outstanding, redirect to 0x100 -> flushing=1, next 3 responses dropped, first output out_pc=0x100, flushing low after third drop.
REQ-021 redirect coincident with mem_valid and with pop -> that response not output, head not consumed, FIFO empty next cycle.
REQ-022 fetch_pc=2^ADDR_WIDTH-4 -> next mem_addr 0, out_pc wraps to 0.
REQ-023 Reset asserted with count=3, outstanding=1 -> next cycle all outputs at REQ-016 values, mem_req low while reset high.

Source files
------------

// File: rtl/prefetch_buffer_if.sv
// prefetch_buffer_if: redirect, memory and decode-side signals of the prefetch buffer
interface prefetch_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  hold;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ready;
  logic                  mem_valid;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_instruction;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic                  flushing;
  modport master (
    input  redirect, redirect_pc, hold, mem_ready, mem_valid, mem_data,
    output mem_req, mem_addr, out_valid, out_instruction, out_pc, flushing
  );
  modport slave (
    output redirect, redirect_pc, hold, mem_ready, mem_valid, mem_data,
    input  mem_req, mem_addr, out_valid, out_instruction, out_pc, flushing
  );
endinterface

// File: rtl/prefetch_buffer.sv
// prefetch_buffer: credit-limited instruction prefetch queue with redirect flush.
// Define PREFETCH_BYPASS_EN to present a response on the empty-queue cycle it arrives.
module prefetch_buffer #(
  parameter int                   DATA_WIDTH  = 32,
  parameter int                   ADDR_WIDTH  = 32,
  parameter int                   DEPTH       = 4,
  parameter int                   INSTR_BYTES = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
  input logic                clock,
  input logic                reset,
  prefetch_buffer_if.master  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(INSTR_BYTES);
  logic [DATA_WIDTH-1:0] instr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_q [DEPTH];
  logic [ADDR_WIDTH-1:0] fetch_pc, resp_pc;
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count, outstanding, stale;
  logic [CW:0]           used;
  logic                  accept, keep, push, pop, bypass, full_stale;
  always_comb begin
    used = {1'b0, count} + {1'b0, outstanding};
    bus.mem_req = !reset && !bus.redirect && used < (CW+1)'(DEPTH);
    bus.mem_addr = fetch_pc;
    accept = bus.mem_req && bus.mem_ready;
    full_stale = stale != '0;
    keep = bus.mem_valid && !bus.redirect && !full_stale;
    pop = count != '0 && !bus.hold && !bus.redirect;
`ifdef PREFETCH_BYPASS_EN
    bypass = keep && count == '0;
    push = keep && !(bypass && !bus.hold);
`else
    bypass = 1'b0;
    push = keep;
`endif
    bus.out_valid = count != '0 || bypass;
    bus.out_instruction = count != '0 ? instr_q[rd_ptr] : bypass ? bus.mem_data : NOP_WORD;
    bus.out_pc = count != '0 ? pc_q[rd_ptr] : bypass ? resp_pc : '0;
    bus.flushing = full_stale;
  end
  always_ff @(posedge clock) begin
    if (push) begin
      instr_q[wr_ptr] <= bus.mem_data;
      pc_q[wr_ptr] <= resp_pc;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      outstanding <= '0;
      stale <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(bus.mem_valid);
      if (bus.redirect) begin
        // everything still in flight after this cycle's response belongs to the old stream
        fetch_pc <= bus.redirect_pc;
        resp_pc <= bus.redirect_pc;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count <= '0;
        stale <= outstanding - CW'(bus.mem_valid);
      end else begin
        fetch_pc <= accept ? fetch_pc + STEP : fetch_pc;
        resp_pc <= keep ? resp_pc + STEP : resp_pc;
        wr_ptr <= wr_ptr + PW'(push);
        rd_ptr <= rd_ptr + PW'(pop);
        count <= count + CW'(push) - CW'(pop);
        stale <= stale - CW'(bus.mem_valid && full_stale);
      end
    end
  end
endmodule

// File: tb/tb_prefetch_buffer.sv
// tb_prefetch_buffer: directed vector table plus randomized run against a queue-based model.
module tb_prefetch_buffer;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  prefetch_buffer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
  prefetch_buffer #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .INSTR_BYTES(4),
    .RESET_PC(32'h0), .NOP_WORD(32'h0)
  ) dut (.clock(clk), .reset(rst), .bus(bus));
  typedef struct {
    logic        rst, redir;
    logic [31:0] rpc;
    logic        hold, ready, valid;
    logic [31:0] data;
    logic        req;
    logic [31:0] addr;
    logic        ov;
    logic [31:0] instr, pc;
    logic        flush;
  } vec_t;
  vec_t tbl[$];
  task automatic add(input logic r, input logic rd, input logic [31:0] rpc, input logic h,
                     input logic rdy, input logic v, input logic [31:0] d, input logic req,
                     input logic [31:0] addr, input logic ov, input logic [31:0] instr,
                     input logic [31:0] pc, input logic fl);
    vec_t e;
    e.rst = r; e.redir = rd; e.rpc = rpc; e.hold = h; e.ready = rdy; e.valid = v; e.data = d;
    e.req = req; e.addr = addr; e.ov = ov; e.instr = instr; e.pc = pc; e.flush = fl;
    tbl.push_back(e);
  endtask
  task automatic drive(input logic r, input logic rd, input logic [31:0] rpc, input logic h,
                       input logic rdy, input logic v, input logic [31:0] d);
    rst = r; bus.redirect = rd; bus.redirect_pc = rpc; bus.hold = h;
    bus.mem_ready = rdy; bus.mem_valid = v; bus.mem_data = d;
  endtask
  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask
  task automatic check_all(input int idx, input logic req, input logic [31:0] addr, input logic ov,
                           input logic [31:0] instr, input logic [31:0] pc, input logic fl);
    vectors++;
    check("mem_req", idx, 32'(bus.mem_req), 32'(req));
    check("mem_addr", idx, bus.mem_addr, addr);
    check("out_valid", idx, 32'(bus.out_valid), 32'(ov));
    check("out_instruction", idx, bus.out_instruction, instr);
    check("out_pc", idx, bus.out_pc, pc);
    check("flushing", idx, 32'(bus.flushing), 32'(fl));
  endtask
  // reference model state
  logic [31:0] m_fetch, m_resp;
  int          m_out, m_stale;
  logic [31:0] f_instr[$], f_pc[$], mem_q[$];
  initial begin
    drive(1, 0, 0, 0, 1, 0, 0);
    @(posedge clk);
`ifndef PREFETCH_BYPASS_EN
    add(1,0,32'h0,0,1,0,32'h0,          0,32'h0,0,32'h0,32'h0,0);
    add(0,0,32'h0,1,1,0,32'h0,          1,32'h0,0,32'h0,32'h0,0);
    add(0,0,32'h0,1,1,1,32'hA0,         1,32'h4,0,32'h0,32'h0,0);
    add(0,0,32'h0,1,1,1,32'hA4,         1,32'h8,1,32'hA0,32'h0,0);
    add(0,0,32'h0,1,1,1,32'hA8,         1,32'hC,1,32'hA0,32'h0,0);
    add(0,0,32'h0,1,1,1,32'hAC,         0,32'h10,1,32'hA0,32'h0,0);
    add(0,0,32'h0,1,1,0,32'h0,          0,32'h10,1,32'hA0,32'h0,0);
    add(0,0,32'h0,0,1,0,32'h0,          0,32'h10,1,32'hA0,32'h0,0);
    add(0,0,32'h0,0,1,0,32'h0,          1,32'h10,1,32'hA4,32'h4,0);
    add(0,0,32'h0,0,1,0,32'h0,          1,32'h14,1,32'hA8,32'h8,0);
    add(0,0,32'h0,1,1,0,32'h0,          1,32'h18,1,32'hAC,32'hC,0);
    add(0,1,32'h100,1,1,0,32'h0,        0,32'h1C,1,32'hAC,32'hC,0);
    add(0,0,32'h0,0,0,1,32'hD0,         1,32'h100,0,32'h0,32'h0,1);
    add(0,0,32'h0,0,0,1,32'hD4,         1,32'h100,0,32'h0,32'h0,1);
    add(0,0,32'h0,0,0,1,32'hD8,         1,32'h100,0,32'h0,32'h0,1);
    add(0,0,32'h0,0,1,0,32'h0,          1,32'h100,0,32'h0,32'h0,0);
    add(0,0,32'h0,0,0,1,32'hB0,         1,32'h104,0,32'h0,32'h0,0);
    add(0,0,32'h0,0,0,0,32'h0,          1,32'h104,1,32'hB0,32'h100,0);
    add(0,0,32'h0,0,1,0,32'h0,          1,32'h104,0,32'h0,32'h0,0);
    add(0,0,32'h0,1,1,1,32'hC4,         1,32'h108,0,32'h0,32'h0,0);
    add(0,1,32'h200,0,1,1,32'hC8,       0,32'h10C,1,32'hC4,32'h104,0);
    add(0,0,32'h0,0,0,0,32'h0,          1,32'h200,0,32'h0,32'h0,0);
    add(0,1,32'hFFFF_FFFC,0,0,0,32'h0,  0,32'h200,0,32'h0,32'h0,0);
    add(0,0,32'h0,0,1,0,32'h0,          1,32'hFFFF_FFFC,0,32'h0,32'h0,0);
    add(0,0,32'h0,0,0,1,32'hE0,         1,32'h0,0,32'h0,32'h0,0);
    add(0,0,32'h0,1,1,0,32'h0,          1,32'h0,1,32'hE0,32'hFFFF_FFFC,0);
    add(0,0,32'h0,0,0,1,32'hE4,         1,32'h4,1,32'hE0,32'hFFFF_FFFC,0);
    add(0,0,32'h0,1,0,0,32'h0,          1,32'h4,1,32'hE4,32'h0,0);
    add(1,0,32'h0,1,0,0,32'h0,          0,32'h4,1,32'hE4,32'h0,0);
    add(1,0,32'h0,1,0,0,32'h0,          0,32'h0,0,32'h0,32'h0,0);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].redir, tbl[i].rpc, tbl[i].hold, tbl[i].ready, tbl[i].valid, tbl[i].data);
      #1;
      check_all(i, tbl[i].req, tbl[i].addr, tbl[i].ov, tbl[i].instr, tbl[i].pc, tbl[i].flush);
    end
`endif
    m_fetch = 0; m_resp = 0; m_out = 0; m_stale = 0;
    for (int c = 0; c < 3000; c++) begin
      logic r, rd, h, rdy, v, keep, byp, ereq, eov;
      logic [31:0] rpc, d, einstr, epc;
      @(negedge clk);
      r = (c == 0) || ($urandom_range(0, 99) == 0);
      rd = !r && ($urandom_range(0, 15) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
      h = $urandom_range(0, 2) == 0;
      rdy = $urandom_range(0, 3) != 0;
      v = !r && mem_q.size() > 0 && $urandom_range(0, 2) != 0;
      d = v ? (mem_q[0] ^ 32'h5A5A_0F0F) : $urandom;
      drive(r, rd, rpc, h, rdy, v, d);
      ereq = !r && !rd && (f_instr.size() + m_out < DEPTH);
      keep = v && !rd && m_stale == 0;
`ifdef PREFETCH_BYPASS_EN
      byp = keep && f_instr.size() == 0;
`else
      byp = 1'b0;
`endif
      eov = f_instr.size() > 0 || byp;
      einstr = f_instr.size() > 0 ? f_instr[0] : byp ? d : 32'h0;
      epc = f_instr.size() > 0 ? f_pc[0] : byp ? m_resp : 32'h0;
      #1;
      check_all(1000 + c, ereq, m_fetch, eov, einstr, epc, m_stale > 0);
      if (r) begin
        m_fetch = 0; m_resp = 0; m_out = 0; m_stale = 0;
        f_instr.delete(); f_pc.delete(); mem_q.delete();
      end else begin
        if (v) begin
          void'(mem_q.pop_front());
          m_out--;
        end
        if (!rd && !h && f_instr.size() > 0) begin
          void'(f_instr.pop_front());
          void'(f_pc.pop_front());
        end
        if (v && !rd) begin
          if (m_stale > 0) m_stale--;
          else begin
            if (!(byp && !h)) begin
              f_instr.push_back(d);
              f_pc.push_back(m_resp);
            end
            m_resp += 4;
          end
        end
        if (ereq && rdy) begin
          mem_q.push_back(m_fetch);
          m_fetch += 4;
          m_out++;
        end
        if (rd) begin
          f_instr.delete(); f_pc.delete();
          m_fetch = rpc; m_resp = rpc; m_stale = m_out;
        end
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
